// File: rtl/ysyx_23060201_ifu.sv
// ysyx_23060201_ifu -- instruction fetch unit for the multi-cycle NPC.
//
// Holds the architectural PC. Issues one AXI-lite-style read per instruction.
// Hands the returned word to decode over a valid/ready handshake, then waits
// for the next PC from execute/writeback before it fetches again. Only one
// read is ever outstanding, and there is no prefetch.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   araddr_o/arvalid_o/arready_i            read address channel
//   rdata_i/rresp_i/rvalid_i/rready_o       read data channel
//   inst_o/inst_pc_o/inst_valid_o/inst_ready_i   instruction to decode
//   dnpc_i/dnpc_valid_i     next PC from execute/writeback
//   fault_o/fault_cause_o   sticky fault (01 misaligned PC, 10 bus error)
//
// Build option YSYX_23060201_IFU_FAULT_EN enables fault detection:
//   - a misaligned dnpc is trapped;
//   - a non-OKAY rresp is trapped.
// Without it, rresp is ignored, dnpc is force-aligned, and fault_o and
// fault_cause_o are tied to 0.
//
// Every output comes from a register. No input reaches an output
// combinationally.
module ysyx_23060201_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic [31:0] dnpc_i,
  input  logic        dnpc_valid_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_VALID, S_NEXT, S_FAULT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, inst_q, inst_pc_q;
  logic        arvalid_q, rready_q, inst_valid_q, fault_q;
  logic [1:0]  fault_cause_q;

  // A new PC is accepted in two cases:
  //   - in VALID, together with the consume;
  //   - any time in NEXT.
  logic        load_w;
  logic [31:0] pc_ld_w;
  assign load_w = dnpc_valid_i &&
                  ((state_q == S_VALID && inst_ready_i) || state_q == S_NEXT);

`ifdef YSYX_23060201_IFU_FAULT_EN
  // Keep the raw dnpc even when it is misaligned, so the faulting PC is visible.
  logic misalign_w;
  assign pc_ld_w   = dnpc_i;
  assign misalign_w = |dnpc_i[1:0];
`else
  assign pc_ld_w = {dnpc_i[31:2], 2'b00};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= NOP;
      inst_pc_q     <= RESET_PC;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_REQ;
          arvalid_q <= 1'b1;
        end
        S_REQ: if (arready_i) begin
          state_q   <= S_WAIT;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        S_WAIT: if (rvalid_i) begin
          rready_q  <= 1'b0;
          inst_pc_q <= pc_q;
`ifdef YSYX_23060201_IFU_FAULT_EN
          if (rresp_i != 2'b00) begin
            state_q       <= S_FAULT;
            fault_q       <= 1'b1;
            fault_cause_q <= 2'b10;
          end else begin
            inst_q       <= rdata_i;
            inst_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end
`else
          inst_q       <= rdata_i;
          inst_valid_q <= 1'b1;
          state_q      <= S_VALID;
`endif
        end
        // The default target after a consume is NEXT. The load block below
        // overrides it when a new PC arrives in the same cycle.
        S_VALID: if (inst_ready_i) begin
          inst_valid_q <= 1'b0;
          state_q      <= S_NEXT;
        end
        S_NEXT:  ;
        S_FAULT: ;
        default: state_q <= S_IDLE;
      endcase

      if (load_w) begin
        pc_q <= pc_ld_w;
`ifdef YSYX_23060201_IFU_FAULT_EN
        if (misalign_w) begin
          state_q       <= S_FAULT;
          fault_q       <= 1'b1;
          fault_cause_q <= 2'b01;
        end else begin
          state_q   <= S_REQ;
          arvalid_q <= 1'b1;
        end
`else
        state_q   <= S_REQ;
        arvalid_q <= 1'b1;
`endif
      end
    end
  end

  assign araddr_o     = pc_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;

`ifdef YSYX_23060201_IFU_FAULT_EN
  assign fault_o       = fault_q;
  assign fault_cause_o = fault_cause_q;
`else
  assign fault_o       = 1'b0;
  assign fault_cause_o = 2'b00;
  logic unused_w;
  assign unused_w = ^{rresp_i, dnpc_i[1:0], fault_q, fault_cause_q};
`endif

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
module tb_ysyx_23060201_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr, rdata = '0, inst, inst_pc, dnpc = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  rresp = '0, fault_cause;
  logic        inst_valid, inst_ready = 1'b0, dnpc_valid = 1'b0, fault;

  int n_chk = 0, n_fail = 0;
  logic [31:0] pc_m;              // architectural PC the model expects
  logic [31:0] inst_m = 32'h13;   // instruction the model expects at decode

  always #5 clk = ~clk;

  ysyx_23060201_ifu dut (
    .clk_i(clk), .rst_i(rst),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .dnpc_i(dnpc), .dnpc_valid_i(dnpc_valid),
    .fault_o(fault), .fault_cause_o(fault_cause)
  );

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory side of one fetch. Entered with the IFU in its first REQ cycle.
  // The address is accepted after da stall cycles and data returns after
  // dr more. Every input that must be ignored carries random noise.
  // When the fetch completes, the model expects inst_valid.
  task automatic fetch(input int da, input int dr, input logic [31:0] data,
                       input logic [1:0] resp, input bit bus_err);
    int wa = 0, wr = 0;
    bit acc = 0, got = 0;
    while (!got) begin
      arready = 0; rvalid = 0; rdata = $urandom; rresp = 2'($urandom);
      inst_ready = 1'($urandom); dnpc_valid = 1'($urandom); dnpc = $urandom;
      if (!acc) begin
        chk("req.arvalid", arvalid, 1);
        chk("req.araddr", araddr, pc_m);
        chk("req.rready", rready, 0);
        rvalid = 1'($urandom);   // stray beat before the address is taken
        if (wa == da) begin arready = 1; acc = 1; end else wa++;
      end else begin
        chk("wait.rready", rready, 1);
        chk("wait.arvalid", arvalid, 0);
        chk("wait.ival", inst_valid, 0);
        if (wr == dr) begin rvalid = 1; rdata = data; rresp = resp; got = 1; end else wr++;
      end
      tick();
    end
    arready = 0; rvalid = 0; inst_ready = 0; dnpc_valid = 0;
    chk("got.arvalid", arvalid, 0);
    chk("got.rready", rready, 0);
    chk("got.inst_pc", inst_pc, pc_m);
    if (!bus_err) begin
      inst_m = data;
      chk("got.ival", inst_valid, 1);
      chk("got.inst", inst, data);
      chk("got.fault", fault, 0);
    end else begin
      chk("berr.ival", inst_valid, 0);
      chk("berr.fault", fault, 1);
      chk("berr.cause", fault_cause, 2'b10);
    end
  endtask

  // Decode side. The bench holds inst_ready low for 'stall' cycles, pulsing
  // dnpc_valid randomly; those pulses must be ignored. It then consumes the
  // instruction in one of two ways:
  //   - together with the new PC;
  //   - alone, then waits 'nwait' cycles in NEXT before supplying the PC.
  task automatic consume(input int stall, input bit together, input int nwait,
                         input logic [31:0] npc);
    for (int i = 0; i < stall; i++) begin
      inst_ready = 0; dnpc_valid = 1'($urandom); dnpc = $urandom;
      tick();
      chk("stall.ival", inst_valid, 1);
      chk("stall.inst", inst, inst_m);
      chk("stall.arvalid", arvalid, 0);
    end
    if (together) begin
      inst_ready = 1; dnpc_valid = 1; dnpc = npc; tick();
    end else begin
      inst_ready = 1; dnpc_valid = 0; dnpc = $urandom; tick();
      for (int i = 0; i < nwait; i++) begin
        chk("next.ival", inst_valid, 0);
        chk("next.arvalid", arvalid, 0);
        inst_ready = 1'($urandom); dnpc_valid = 0; tick();
      end
      chk("next.ival", inst_valid, 0);
      inst_ready = 1'($urandom); dnpc_valid = 1; dnpc = npc; tick();
    end
    inst_ready = 0; dnpc_valid = 0;
    chk("ld.ival", inst_valid, 0);
`ifdef YSYX_23060201_IFU_FAULT_EN
    if (npc[1:0] != 2'b00) begin
      pc_m = npc;
      chk("mis.fault", fault, 1);
      chk("mis.cause", fault_cause, 2'b01);
      chk("mis.arvalid", arvalid, 0);
      chk("mis.araddr", araddr, npc);
      return;
    end
`endif
    pc_m = npc & 32'hFFFF_FFFC;
    chk("ld.arvalid", arvalid, 1);
    chk("ld.araddr", araddr, pc_m);
  endtask

  initial begin
    logic [31:0] npc;
    logic [1:0]  rr;
    // Reset state
    rst = 1; tick(); tick();
    chk("rst.arvalid", arvalid, 0);
    chk("rst.rready", rready, 0);
    chk("rst.ival", inst_valid, 0);
    chk("rst.fault", fault, 0);
    chk("rst.cause", fault_cause, 0);
    chk("rst.inst", inst, 32'h13);
    chk("rst.inst_pc", inst_pc, RST_PC);
    chk("rst.araddr", araddr, RST_PC);
    pc_m = RST_PC;
    rst = 0; tick();   // IDLE -> REQ

    // Zero-wait fetch: inst_valid in the 3rd cycle of the fetch
    fetch(0, 0, 32'h0000_0297, 2'b00, 0);
    // Stall 4 cycles with stray dnpc pulses, then a back-to-back redirect
    consume(4, 1, 0, 32'h8000_0010);
    // arready late by 3 and rvalid late by 2: inst_valid comes 5 cycles later
    fetch(3, 2, 32'h1234_5678, 2'b00, 0);
    consume(0, 0, 2, 32'h8000_0020);

    // Reset in WAIT, with a late read beat during and after reset
    arready = 1; tick(); arready = 0;
    chk("w.rready", rready, 1);
    rst = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; tick();
    chk("wr.arvalid", arvalid, 0);
    chk("wr.rready", rready, 0);
    chk("wr.ival", inst_valid, 0);
    chk("wr.araddr", araddr, RST_PC);
    rst = 0; tick();   // IDLE -> REQ, beat ignored
    rvalid = 0;
    chk("wr.inst", inst, 32'h13);
    pc_m = RST_PC;
    fetch(1, 1, 32'h0040_0093, 2'b00, 0);
    consume(1, 1, 0, 32'h8000_0100);

    // Randomized fetch/consume sequence
    for (int k = 0; k < 25; k++) begin
`ifdef YSYX_23060201_IFU_FAULT_EN
      rr = 2'b00;
`else
      rr = 2'($urandom);   // rresp has no effect in this build
`endif
      fetch($urandom_range(0, 4), $urandom_range(0, 4), $urandom, rr, 0);
      npc = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
`ifndef YSYX_23060201_IFU_FAULT_EN
      npc[1:0] = 2'($urandom);
`endif
      consume($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), npc);
    end

    // Misaligned redirect
    fetch(0, 1, 32'h0000_0513, 2'b00, 0);
    consume(0, 1, 0, 32'h8000_0012);
`ifdef YSYX_23060201_IFU_FAULT_EN
    // The fault is sticky; only reset leaves it.
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'($urandom); arready = 1'($urandom); dnpc_valid = 1'($urandom); tick();
      chk("fs.fault", fault, 1);
      chk("fs.arvalid", arvalid, 0);
      chk("fs.rready", rready, 0);
    end
    arready = 0; rvalid = 0; dnpc_valid = 0;
    rst = 1; tick(); rst = 0; tick();
    pc_m = RST_PC;
    chk("fr.fault", fault, 0);
    // Bus error: no inst_valid, ever
    fetch(1, 0, 32'h0000_0297, 2'b10, 1);
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'($urandom); inst_ready = 1'($urandom); tick();
      chk("be.ival", inst_valid, 0);
      chk("be.cause", fault_cause, 2'b10);
    end
`else
    fetch(0, 0, 32'h0000_0613, 2'b11, 0);
    chk("mis.inst_pc", inst_pc, 32'h8000_0010);
    chk("mis.fault", fault, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
